// File: rtl/mtsp_sf_seq_if.sv
// Bus interface of the SF lane sequencer: instruction input, SF unit issue/return
// and vector write-back. The master side drives instructions and SF results, the
// slave side is the sequencer itself.
interface mtsp_sf_seq_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned OPW   = 4,
    parameter int unsigned TAGW  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_en;
    logic [LANES*OPW-1:0]    in_op;
    logic [LANES*DW-1:0]     in_data;
    logic [TAGW-1:0]         in_tag;

    logic                    sf_valid;
    logic [OPW-1:0]          sf_op;
    logic [DW-1:0]           sf_data;
    logic                    sf_rvalid;
    logic [DW-1:0]           sf_rdata;

    logic                    out_valid;
    logic [LANES-1:0]        out_we;
    logic [LANES*DW-1:0]     out_data;
    logic [TAGW-1:0]         out_tag;

    modport master (
        output in_valid, in_en, in_op, in_data, in_tag, sf_rvalid, sf_rdata,
        input  in_ready, sf_valid, sf_op, sf_data, out_valid, out_we, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_en, in_op, in_data, in_tag, sf_rvalid, sf_rdata,
        output in_ready, sf_valid, sf_op, sf_data, out_valid, out_we, out_data, out_tag
    );
endinterface

// File: rtl/mtsp_sf_seq.sv
// Special-function lane sequencer: accepts one vector SF instruction, issues its
// enabled lanes lowest-first one per cycle to a fixed-latency SF unit, gathers the
// returning results lane-wise and writes them back as one masked vector.
// Optional build macro MTSP_SF_SEQ_CHECK_EN adds a sticky err output that flags any
// cycle where the SF unit's result strobe disagrees with the expected return slot.
module mtsp_sf_seq #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned OPW   = 4,
    parameter int unsigned TAGW  = 2,
    parameter int unsigned LAT   = 3
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MTSP_SF_SEQ_CHECK_EN
    output logic         err,
`endif
    mtsp_sf_seq_if.slave bus
);
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LANES-1:0] pending_q, pending_d;
    logic [OPW-1:0]   op_q   [LANES];
    logic [DW-1:0]    data_q [LANES];
    logic [DW-1:0]    res_q  [LANES];
    logic [LANES-1:0] we_q;
    logic [TAGW-1:0]  tag_q;
    logic             out_valid_q;
    logic [LAT-1:0]   pipe_v_q;
    logic [IW-1:0]    pipe_idx_q [LAT];

    logic             accept;
    logic             issuing;
    logic             pipe_busy;
    logic             wb_now;
    logic [IW-1:0]    issue_idx;

    assign accept  = bus.in_valid && (state_q == StIdle);
    assign issuing = (state_q == StIssue);
    // Last result lands on the same edge that raises the write-back strobe.
    assign wb_now  = (state_q == StDrain) && !pipe_busy;

    // Lowest pending lane is the next one to issue.
    always_comb begin
        issue_idx = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (pending_q[i]) issue_idx = IW'(i);
        end
    end

    // Any lane still in flight other than the one at the pipe output.
    always_comb begin
        pipe_busy = 1'b0;
        for (int s = 0; s < int'(LAT) - 1; s++) begin
            pipe_busy = pipe_busy | pipe_v_q[s];
        end
    end

    // Pending mask: loaded on accept, one bit retired per issue cycle.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = bus.in_en;
        end else if (issuing) begin
            pending_d[issue_idx] = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (bus.in_en != '0)) state_d = StIssue;
            StIssue: if (pending_d == '0) state_d = StDrain;
            StDrain: if (!pipe_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and pending mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Latch per-lane operands of the accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LANES); i++) begin
                op_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < int'(LANES); i++) begin
                op_q[i]   <= bus.in_op[i*OPW +: OPW];
                data_q[i] <= bus.in_data[i*DW +: DW];
            end
        end
    end

    // Latency pipe tracks which lane the SF unit returns each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v_q <= '0;
            for (int s = 0; s < int'(LAT); s++) pipe_idx_q[s] <= '0;
        end else begin
            pipe_v_q[0]   <= issuing;
            pipe_idx_q[0] <= issue_idx;
            for (int s = 1; s < int'(LAT); s++) begin
                pipe_v_q[s]   <= pipe_v_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
        end
    end

    // Result gathering and write-back registers; held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            we_q        <= '0;
            tag_q       <= '0;
            for (int i = 0; i < int'(LANES); i++) res_q[i] <= '0;
        end else begin
            out_valid_q <= (accept && (bus.in_en == '0)) || wb_now;
            if (accept) begin
                we_q  <= bus.in_en;
                tag_q <= bus.in_tag;
                for (int i = 0; i < int'(LANES); i++) res_q[i] <= '0;
            end else if (pipe_v_q[LAT-1]) begin
                res_q[pipe_idx_q[LAT-1]] <= bus.sf_rdata;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.sf_valid  = issuing;
    assign bus.sf_op     = issuing ? op_q[issue_idx] : '0;
    assign bus.sf_data   = issuing ? data_q[issue_idx] : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_we    = we_q;
    assign bus.out_tag   = tag_q;

    for (genvar g = 0; g < int'(LANES); g++) begin : g_pack
        assign bus.out_data[g*DW +: DW] = res_q[g];
    end

`ifdef MTSP_SF_SEQ_CHECK_EN
    logic err_q;
    logic err_now;

    assign err_now = bus.sf_rvalid != pipe_v_q[LAT-1];

    // Sticky until reset; reported in the offending cycle already.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q | err_now;
`else
    logic unused_sf_rvalid;
    assign unused_sf_rvalid = bus.sf_rvalid;
`endif
endmodule

// File: tb/tb_mtsp_sf_seq.sv
// Bench for mtsp_sf_seq: random and directed instructions, an SF unit model that
// answers after LAT cycles, and a schedule-level reference for issue order, timing
// and write-back contents.
module tb_mtsp_sf_seq;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned OPW   = 4;
    localparam int unsigned TAGW  = 2;
    localparam int unsigned LAT   = 3;
    localparam int unsigned VW    = LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mtsp_sf_seq_if #(.LANES(LANES), .DW(DW), .OPW(OPW), .TAGW(TAGW)) bus ();

`ifdef MTSP_SF_SEQ_CHECK_EN
    logic err;
`endif

    mtsp_sf_seq #(
        .LANES(LANES), .DW(DW), .OPW(OPW), .TAGW(TAGW), .LAT(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef MTSP_SF_SEQ_CHECK_EN
        .err (err),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [VW-1:0] got,
                            input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SF unit transfer function used by both the unit model and the reference.
    function automatic logic [DW-1:0] sf_fn(input logic [OPW-1:0] op, input logic [DW-1:0] d);
        return (d ^ 32'hA5C3_0F69) + {d[15:0], 12'h000, op};
    endfunction

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } res_t;

    typedef struct {
        int             c;
        logic [OPW-1:0] op;
        logic [DW-1:0]  d;
    } iss_t;

    int   cyc       = 0;
    res_t rq[$];
    iss_t iq[$];
    int   wb_cyc    = -1;
    int   ready_cyc = 0;
    bit   held      = 1'b0;
    logic [LANES-1:0] e_we   = '0;
    logic [TAGW-1:0]  e_tag  = '0;
    logic [VW-1:0]    e_data = '0;
    bit   drop_now  = 1'b0;
    bit   exp_err   = 1'b0;
    int   drop_at   = -1;
    int   res_count = 0;

    // SF unit model: returns each issued lane LAT cycles later, garbage data otherwise.
    initial begin
        bus.sf_rvalid = 1'b0;
        bus.sf_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            drop_now      = 1'b0;
            bus.sf_rvalid = 1'b0;
            bus.sf_rdata  = $urandom;
            if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
                bus.sf_rdata  = rq[0].val;
                bus.sf_rvalid = 1'b1;
                rq.pop_front();
                res_count++;
                if (res_count == drop_at) begin
                    bus.sf_rvalid = 1'b0;
                    drop_now      = 1'b1;
                end
            end
        end
    end

    // Reference schedule: accept at edge T issues lanes at T+1..T+k, writes back at
    // T+k+LAT+1 (T+1 when no lane is enabled); ready again in the write-back cycle.
    always @(negedge clk) begin
        int k;
        if (rst) begin
            rq.delete();
            iq.delete();
            wb_cyc    = -1;
            ready_cyc = 0;
            held      = 1'b0;
            exp_err   = 1'b0;
        end else begin
            check_eq("in_ready", VW'(bus.in_ready), VW'(cyc >= ready_cyc));
            if (iq.size() > 0 && iq[0].c == cyc) begin
                check_eq("sf_valid", VW'(bus.sf_valid), VW'(1'b1));
                check_eq("sf_op", VW'(bus.sf_op), VW'(iq[0].op));
                check_eq("sf_data", VW'(bus.sf_data), VW'(iq[0].d));
                iq.pop_front();
            end else begin
                check_eq("sf_valid", VW'(bus.sf_valid), VW'(1'b0));
            end
            if (bus.sf_valid === 1'b1) begin
                rq.push_back('{due: cyc + int'(LAT), val: sf_fn(bus.sf_op, bus.sf_data)});
            end
            check_eq("out_valid", VW'(bus.out_valid), VW'(cyc == wb_cyc));
            if (cyc == wb_cyc) held = 1'b1;
            if (held) begin
                check_eq("out_we", VW'(bus.out_we), VW'(e_we));
                check_eq("out_tag", VW'(bus.out_tag), VW'(e_tag));
                check_eq("out_data", bus.out_data, e_data);
            end
`ifdef MTSP_SF_SEQ_CHECK_EN
            if (drop_now) exp_err = 1'b1;
            check_eq("err", VW'(err), VW'(exp_err));
`endif
            if (bus.in_valid && cyc >= ready_cyc) begin
                k      = 0;
                e_we   = bus.in_en;
                e_tag  = bus.in_tag;
                e_data = '0;
                held   = 1'b0;
                for (int i = 0; i < int'(LANES); i++) begin
                    if (bus.in_en[i]) begin
                        k++;
                        iq.push_back('{c: cyc + k, op: bus.in_op[i*OPW +: OPW],
                                       d: bus.in_data[i*DW +: DW]});
                        e_data[i*DW +: DW] = sf_fn(bus.in_op[i*OPW +: OPW],
                                                   bus.in_data[i*DW +: DW]);
                    end
                end
                wb_cyc    = cyc + k + ((k > 0) ? int'(LAT) : 0) + 1;
                ready_cyc = wb_cyc;
            end
        end
    end

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_in_ready"}, VW'(bus.in_ready), VW'(1'b1));
        check_eq({pfx, "_sf_valid"}, VW'(bus.sf_valid), VW'(1'b0));
        check_eq({pfx, "_sf_op"}, VW'(bus.sf_op), '0);
        check_eq({pfx, "_sf_data"}, VW'(bus.sf_data), '0);
        check_eq({pfx, "_out_valid"}, VW'(bus.out_valid), VW'(1'b0));
        check_eq({pfx, "_out_we"}, VW'(bus.out_we), '0);
        check_eq({pfx, "_out_data"}, bus.out_data, '0);
        check_eq({pfx, "_out_tag"}, VW'(bus.out_tag), '0);
`ifdef MTSP_SF_SEQ_CHECK_EN
        check_eq({pfx, "_err"}, VW'(err), VW'(1'b0));
`endif
    endtask

    // Offer one instruction and wait for its accept edge; optionally keep in_valid high.
    task automatic send(input logic [LANES-1:0] en, input logic [TAGW-1:0] tag,
                        input logic [LANES*OPW-1:0] ops, input logic [VW-1:0] datas,
                        input bit hold);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_en    = en;
        bus.in_tag   = tag;
        bus.in_op    = ops;
        bus.in_data  = datas;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_timeout", VW'(w < 40), VW'(1'b1));
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_en    = LANES'($urandom);
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (cyc <= ready_cyc && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq("idle_timeout", VW'(w < 100), VW'(1'b1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_en    = '0;
        bus.in_op    = '0;
        bus.in_data  = '0;
        bus.in_tag   = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // All four lanes, operands 1..4.
        send(4'b1111, 2'd0, 16'($urandom), {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        wait_idle();
        // Sparse mask with tag.
        send(4'b1010, 2'd2, 16'($urandom), rand_data(), 1'b0);
        wait_idle();
        // Empty mask: immediate write-back, no issue.
        send(4'b0000, 2'd1, 16'($urandom), rand_data(), 1'b0);
        wait_idle();
        // Back-to-back with in_valid held.
        send(4'b0011, 2'd1, 16'($urandom), rand_data(), 1'b1);
        send(4'b1100, 2'd3, 16'($urandom), rand_data(), 1'b0);
        wait_idle();

        // Reset in cycle 3 of a full-mask instruction, then a clean instruction.
        send(4'b1111, 2'd3, 16'($urandom), {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 2) begin @(posedge clk); #1; end
        send(4'b0110, 2'd1, 16'($urandom), rand_data(), 1'b0);
        wait_idle();

        // Random traffic, mixing gaps and back-to-back offers.
        for (int n = 0; n < 60; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send(LANES'($urandom), TAGW'($urandom), 16'($urandom), rand_data(), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        end
        bus.in_valid = 1'b0;
        wait_idle();

        // Drop the result strobe on the second returning lane.
        drop_at = res_count + 2;
        send(4'b1111, 2'd2, 16'($urandom), rand_data(), 1'b0);
        wait_idle();
        repeat (4) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
